// File: rtl/cpu_8bit_pkg.sv
// Shared types for the 8-bit CPU microsequencer: opcodes, sequencer states,
// ALU operation codes and the control word that groups every datapath strobe.
package cpu_8bit_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_HLT = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        ST_T0_FETCH_ADDR  = 3'd0,
        ST_T1_FETCH_INSTR = 3'd1,
        ST_T2_DECODE      = 3'd2,
        ST_T3_EXEC        = 3'd3,
        ST_T4_EXEC        = 3'd4,
        ST_T5_EXEC        = 3'd5,
        ST_HALT           = 3'd6
    } state_t;

    localparam logic [3:0] ALU_OP_ADD = 4'h0;
    localparam logic [3:0] ALU_OP_SUB = 4'h1;

    // Strobes ending in n are active low; alu_sel and alu_flag_sel are active high.
    typedef struct packed {
        logic       pc_cntn;
        logic       pc_din;
        logic       pc_den;
        logic       mar_wrtn;
        logic       mem_rdn;
        logic       mem_wrtn;
        logic       ir_wrtn;
        logic       ir_rdn;
        logic       a_wrtn;
        logic       a_rdn;
        logic       b_wrtn;
        logic       b_rdn;
        logic       alu_sel;
        logic       alu_flag_sel;
        logic [3:0] alu_opcode;
        logic       cin;
    } ctrl_word_t;

    function automatic ctrl_word_t ctrl_idle();
        ctrl_word_t w;
        w.pc_cntn      = 1'b1;
        w.pc_din       = 1'b1;
        w.pc_den       = 1'b1;
        w.mar_wrtn     = 1'b1;
        w.mem_rdn      = 1'b1;
        w.mem_wrtn     = 1'b1;
        w.ir_wrtn      = 1'b1;
        w.ir_rdn       = 1'b1;
        w.a_wrtn       = 1'b1;
        w.a_rdn        = 1'b1;
        w.b_wrtn       = 1'b1;
        w.b_rdn        = 1'b1;
        w.alu_sel      = 1'b0;
        w.alu_flag_sel = 1'b0;
        w.alu_opcode   = 4'h0;
        w.cin          = 1'b0;
        return w;
    endfunction

endpackage

// File: rtl/ctrl_ucode_decode.sv
// Combinational microcode decode: sequencer state plus latched opcode to the
// control word. Holds no state; the sequencer top owns the FSM register.
module ctrl_ucode_decode
    import cpu_8bit_pkg::*;
(
    input  state_t     i_state,
    input  opcode_t    i_opcode,
    input  logic       i_go,
    output ctrl_word_t o_ctrl
);

    always_comb begin
        o_ctrl = ctrl_idle();
        case (i_state)
            ST_T0_FETCH_ADDR: begin
                // When single-stepping, T0 idles until the step request is latched.
                if (i_go) begin
                    o_ctrl.pc_den   = 1'b0;
                    o_ctrl.mar_wrtn = 1'b0;
                end
            end
            ST_T1_FETCH_INSTR: begin
                o_ctrl.mem_rdn = 1'b0;
                o_ctrl.ir_wrtn = 1'b0;
                o_ctrl.pc_cntn = 1'b0;
            end
            ST_T3_EXEC: begin
                case (i_opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        o_ctrl.ir_rdn   = 1'b0;
                        o_ctrl.mar_wrtn = 1'b0;
                    end
                    OP_LDI: begin
                        o_ctrl.ir_rdn = 1'b0;
                        o_ctrl.a_wrtn = 1'b0;
                    end
                    OP_JMP, OP_JC, OP_JZ: begin
                        o_ctrl.ir_rdn = 1'b0;
                        o_ctrl.pc_din = 1'b0;
                    end
                    default: ;
                endcase
            end
            ST_T4_EXEC: begin
                case (i_opcode)
                    OP_LDA: begin
                        o_ctrl.mem_rdn = 1'b0;
                        o_ctrl.a_wrtn  = 1'b0;
                    end
                    OP_ADD, OP_SUB: begin
                        o_ctrl.mem_rdn = 1'b0;
                        o_ctrl.b_wrtn  = 1'b0;
                    end
                    OP_STA: begin
                        o_ctrl.a_rdn    = 1'b0;
                        o_ctrl.mem_wrtn = 1'b0;
                    end
                    default: ;
                endcase
            end
            ST_T5_EXEC: begin
                if (i_opcode == OP_ADD || i_opcode == OP_SUB) begin
                    o_ctrl.alu_sel      = 1'b1;
                    o_ctrl.a_wrtn       = 1'b0;
                    o_ctrl.alu_flag_sel = 1'b1;
                    o_ctrl.alu_opcode   = (i_opcode == OP_SUB) ? ALU_OP_SUB : ALU_OP_ADD;
                    o_ctrl.cin          = (i_opcode == OP_SUB);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_sequencer.sv
// Fetch/decode/execute microsequencer for the 8-bit CPU datapath.
// Optional CPU_SINGLE_STEP_EN adds i_step and gates each instruction start on it.
module cpu_ctrl_sequencer
    import cpu_8bit_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
`ifdef CPU_SINGLE_STEP_EN
    input  logic       i_step,
`endif
    input  logic [7:0] i_ir_data,
    input  logic       i_zr,
    input  logic       i_co,
    output logic       o_pc_cntn,
    output logic       o_pc_din,
    output logic       o_pc_den,
    output logic       o_mar_wrtn,
    output logic       o_mem_rdn,
    output logic       o_mem_wrtn,
    output logic       o_ir_wrtn,
    output logic       o_ir_rdn,
    output logic       o_a_wrtn,
    output logic       o_a_rdn,
    output logic       o_b_wrtn,
    output logic       o_b_rdn,
    output logic       o_alu_sel,
    output logic       o_alu_flag_sel,
    output logic [3:0] o_alu_opcode,
    output logic       o_cin,
    output logic       o_halted
);

    state_t     r_state;
    opcode_t    r_opcode;
    opcode_t    w_ir_op;
    logic       w_go;
    ctrl_word_t w_ctrl;
    ctrl_word_t w_out;
    logic       w_unused_operand;

    assign w_ir_op = opcode_t'(i_ir_data[7:4]);
    // The operand nibble is routed by the datapath itself, never by the sequencer.
    assign w_unused_operand = ^i_ir_data[3:0];

`ifdef CPU_SINGLE_STEP_EN
    logic r_go;
    assign w_go = r_go;
`else
    assign w_go = 1'b1;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_T0_FETCH_ADDR;
            r_opcode <= OP_NOP;
`ifdef CPU_SINGLE_STEP_EN
            r_go     <= 1'b0;
`endif
        end else begin
`ifdef CPU_SINGLE_STEP_EN
            // Sample i_step while waiting in T0 and on the edge that returns to T0.
            if (r_state != ST_T0_FETCH_ADDR || !r_go)
                r_go <= i_step;
`endif
            case (r_state)
                ST_T0_FETCH_ADDR: begin
                    if (w_go)
                        r_state <= ST_T1_FETCH_INSTR;
                end
                ST_T1_FETCH_INSTR: r_state <= ST_T2_DECODE;
                ST_T2_DECODE: begin
                    r_opcode <= w_ir_op;
                    case (w_ir_op)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI, OP_JMP:
                            r_state <= ST_T3_EXEC;
                        OP_JC:   r_state <= i_co ? ST_T3_EXEC : ST_T0_FETCH_ADDR;
                        OP_JZ:   r_state <= i_zr ? ST_T3_EXEC : ST_T0_FETCH_ADDR;
                        OP_HLT:  r_state <= ST_HALT;
                        default: r_state <= ST_T0_FETCH_ADDR;
                    endcase
                end
                ST_T3_EXEC: begin
                    if (r_opcode == OP_LDA || r_opcode == OP_ADD ||
                        r_opcode == OP_SUB || r_opcode == OP_STA)
                        r_state <= ST_T4_EXEC;
                    else
                        r_state <= ST_T0_FETCH_ADDR;
                end
                ST_T4_EXEC: begin
                    if (r_opcode == OP_ADD || r_opcode == OP_SUB)
                        r_state <= ST_T5_EXEC;
                    else
                        r_state <= ST_T0_FETCH_ADDR;
                end
                ST_T5_EXEC: r_state <= ST_T0_FETCH_ADDR;
                ST_HALT:    r_state <= ST_HALT;
                default:    r_state <= ST_T0_FETCH_ADDR;
            endcase
        end
    end

    ctrl_ucode_decode u_decode (
        .i_state  (r_state),
        .i_opcode (r_opcode),
        .i_go     (w_go),
        .o_ctrl   (w_ctrl)
    );

    // Reset forces every strobe inactive so an aborted instruction cannot write on the reset edge.
    always_comb begin
        w_out = w_ctrl;
        if (i_rst)
            w_out = ctrl_idle();
    end

    assign o_pc_cntn      = w_out.pc_cntn;
    assign o_pc_din       = w_out.pc_din;
    assign o_pc_den       = w_out.pc_den;
    assign o_mar_wrtn     = w_out.mar_wrtn;
    assign o_mem_rdn      = w_out.mem_rdn;
    assign o_mem_wrtn     = w_out.mem_wrtn;
    assign o_ir_wrtn      = w_out.ir_wrtn;
    assign o_ir_rdn       = w_out.ir_rdn;
    assign o_a_wrtn       = w_out.a_wrtn;
    assign o_a_rdn        = w_out.a_rdn;
    assign o_b_wrtn       = w_out.b_wrtn;
    assign o_b_rdn        = w_out.b_rdn;
    assign o_alu_sel      = w_out.alu_sel;
    assign o_alu_flag_sel = w_out.alu_flag_sel;
    assign o_alu_opcode   = w_out.alu_opcode;
    assign o_cin          = w_out.cin;
    assign o_halted       = !i_rst && (r_state == ST_HALT);

endmodule

// File: tb/tb_cpu_ctrl_sequencer.sv
// Bench for cpu_ctrl_sequencer: a small datapath driven by the DUT strobes,
// checked against an instruction-level CPU model (directed + random programs).
module tb_cpu_ctrl_sequencer;

    logic       clk;
    logic       rst;
    logic [7:0] ir_data;
    logic       zr, co;
    logic       pc_cntn, pc_din, pc_den, mar_wrtn, mem_rdn, mem_wrtn;
    logic       ir_wrtn, ir_rdn, a_wrtn, a_rdn, b_wrtn, b_rdn;
    logic       alu_sel, alu_flag_sel, cin, halted;
    logic [3:0] alu_opcode;

`ifdef CPU_SINGLE_STEP_EN
    logic step;
    localparam int SS_LAT = 1;
`else
    localparam int SS_LAT = 0;
`endif

    localparam logic [19:0] OBS_IDLE = {12'hFFF, 8'h00};
    localparam logic [19:0] OBS_T0   = {12'hCFF, 8'h00};
    localparam logic [19:0] OBS_AFTER_RST = (SS_LAT != 0) ? OBS_IDLE : OBS_T0;

    // Datapath emulation (environment only)
    logic [7:0] img [16];
    logic [7:0] dp_mem [16];
    logic [3:0] dp_pc, dp_mar;
    logic [7:0] dp_ir, dp_a, dp_b;
    logic       dp_zr, dp_co;
    logic [7:0] w_bus;
    logic [8:0] w_sum;
    int         w_nd;
    int         n_contend = 0;
    int         n_pcdin = 0;
    int         n_wr = 0;

    // Instruction-level reference model
    logic [7:0] m_mem [16];
    logic [3:0] m_pc;
    logic [7:0] m_a;
    logic       m_zr, m_co, m_halt;

    int n_checks = 0;
    int n_errors = 0;

    wire [19:0] obs = {pc_cntn, pc_din, pc_den, mar_wrtn, mem_rdn, mem_wrtn,
                       ir_wrtn, ir_rdn, a_wrtn, a_rdn, b_wrtn, b_rdn,
                       alu_sel, alu_flag_sel, alu_opcode, cin, halted};

    assign ir_data = dp_ir;
    assign zr      = dp_zr;
    assign co      = dp_co;

    cpu_ctrl_sequencer dut (
        .i_clk          (clk),
        .i_rst          (rst),
`ifdef CPU_SINGLE_STEP_EN
        .i_step         (step),
`endif
        .i_ir_data      (ir_data),
        .i_zr           (zr),
        .i_co           (co),
        .o_pc_cntn      (pc_cntn),
        .o_pc_din       (pc_din),
        .o_pc_den       (pc_den),
        .o_mar_wrtn     (mar_wrtn),
        .o_mem_rdn      (mem_rdn),
        .o_mem_wrtn     (mem_wrtn),
        .o_ir_wrtn      (ir_wrtn),
        .o_ir_rdn       (ir_rdn),
        .o_a_wrtn       (a_wrtn),
        .o_a_rdn        (a_rdn),
        .o_b_wrtn       (b_wrtn),
        .o_b_rdn        (b_rdn),
        .o_alu_sel      (alu_sel),
        .o_alu_flag_sel (alu_flag_sel),
        .o_alu_opcode   (alu_opcode),
        .o_cin          (cin),
        .o_halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        w_nd  = 0;
        w_bus = 8'h00;
        if (alu_opcode == 4'h1)
            w_sum = {1'b0, dp_a} + {1'b0, ~dp_b} + {8'h00, cin};
        else
            w_sum = {1'b0, dp_a} + {1'b0, dp_b} + {8'h00, cin};
        if (!pc_den)  begin w_nd = w_nd + 1; w_bus = {4'h0, dp_pc}; end
        if (!mem_rdn) begin w_nd = w_nd + 1; w_bus = dp_mem[dp_mar]; end
        if (!ir_rdn)  begin w_nd = w_nd + 1; w_bus = {4'h0, dp_ir[3:0]}; end
        if (!a_rdn)   begin w_nd = w_nd + 1; w_bus = dp_a; end
        if (!b_rdn)   begin w_nd = w_nd + 1; w_bus = dp_b; end
        if (alu_sel)  begin w_nd = w_nd + 1; w_bus = w_sum[7:0]; end
    end

    always @(posedge clk) begin
        if (w_nd > 1) n_contend <= n_contend + 1;
        if (!pc_din)  n_pcdin <= n_pcdin + 1;
        if (!a_wrtn || !b_wrtn || !mem_wrtn || !pc_din || alu_flag_sel)
            n_wr <= n_wr + 1;
        if (rst) begin
            for (int i = 0; i < 16; i++) dp_mem[i] <= img[i];
            dp_pc <= 4'h0; dp_mar <= 4'h0; dp_ir <= 8'h00;
            dp_a  <= 8'h00; dp_b <= 8'h00; dp_zr <= 1'b0; dp_co <= 1'b0;
        end else begin
            if (!pc_din)        dp_pc <= w_bus[3:0];
            else if (!pc_cntn)  dp_pc <= dp_pc + 4'h1;
            if (!mar_wrtn) dp_mar <= w_bus[3:0];
            if (!mem_wrtn) dp_mem[dp_mar] <= w_bus;
            if (!ir_wrtn)  dp_ir <= w_bus;
            if (!a_wrtn)   dp_a <= w_bus;
            if (!b_wrtn)   dp_b <= w_bus;
            if (alu_flag_sel) begin
                dp_zr <= (w_sum[7:0] == 8'h00);
                dp_co <= w_sum[8];
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic model_init();
        for (int i = 0; i < 16; i++) m_mem[i] = img[i];
        m_pc = 4'h0; m_a = 8'h00; m_zr = 1'b0; m_co = 1'b0; m_halt = 1'b0;
    endtask

    // Runs k instructions (stopping at HLT) and returns the clock cycles they take.
    task automatic model_run(input int k, output int cyc);
        logic [3:0] op, arg;
        int         x, y;
        cyc = 0;
        for (int n = 0; n < k && !m_halt; n++) begin
            op   = m_mem[m_pc][7:4];
            arg  = m_mem[m_pc][3:0];
            m_pc = m_pc + 4'h1;
            case (op)
                4'h1: begin m_a = m_mem[arg]; cyc += 5; end
                4'h2, 4'h3: begin
                    x = int'(m_a);
                    y = int'(m_mem[arg]);
                    if (op == 4'h2) begin
                        m_co = (x + y) > 255;
                        m_a  = 8'((x + y) % 256);
                    end else begin
                        m_co = (x >= y);
                        m_a  = 8'((x - y + 256) % 256);
                    end
                    m_zr = (m_a == 8'h00);
                    cyc += 6;
                end
                4'h4: begin m_mem[arg] = m_a; cyc += 5; end
                4'h5: begin m_a = {4'h0, arg}; cyc += 4; end
                4'h6: begin m_pc = arg; cyc += 4; end
                4'h7: if (m_co) begin m_pc = arg; cyc += 4; end else cyc += 3;
                4'h8: if (m_zr) begin m_pc = arg; cyc += 4; end else cyc += 3;
                4'hF: begin m_halt = 1'b1; cyc += 3; end
                default: cyc += 3;
            endcase
        end
    endtask

    function automatic logic [127:0] pack_dp_mem();
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[i*8 +: 8] = dp_mem[i];
        return v;
    endfunction

    function automatic logic [127:0] pack_m_mem();
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[i*8 +: 8] = m_mem[i];
        return v;
    endfunction

    task automatic clear_img();
        for (int i = 0; i < 16; i++) img[i] = 8'h00;
    endtask

    initial begin
        int base_wr, base_pcdin, cyc, k;
        rst = 1'b1;
`ifdef CPU_SINGLE_STEP_EN
        step = 1'b1;
`endif
        clear_img();
        repeat (2) @(negedge clk);
        check("reset_idle", 128'(obs), 128'(OBS_IDLE));

        // Reset held 3 cycles in the middle of ADD (state T4)
        clear_img();
        img[0] = 8'h2F; img[15] = 8'h03;
        do_reset();
        tick(4 + SS_LAT);
        rst = 1'b1;
        base_wr = n_wr;
        #1;
        check("rst_midadd_c0", 128'(obs), 128'(OBS_IDLE));
        for (int i = 1; i <= 3; i++) begin
            tick(1);
            check("rst_midadd_hold", 128'(obs), 128'(OBS_IDLE));
        end
        check("rst_midadd_nowrite", 128'(n_wr - base_wr), 128'(0));
        rst = 1'b0;
        #1;
        check("rst_release_t0", 128'(obs), 128'(OBS_AFTER_RST));
        $display("txn reset-mid-ADD released, obs=%05h", obs);

        // LDA 0xE, ADD 0xF, STA 0xD, HLT
        clear_img();
        img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'h4D; img[3] = 8'hF0;
        img[14] = 8'h05; img[15] = 8'h03;
        do_reset();
        tick(18 + SS_LAT);
        check("prog1_not_halted_yet", 128'(halted), 128'(0));
        tick(1);
        check("prog1_halted", 128'(halted), 128'(1));
        check("prog1_memD", 128'(dp_mem[13]), 128'(8'h08));
        check("prog1_halt_idle", 128'(obs), 128'(OBS_IDLE | 20'h1));
        $display("txn LDA/ADD/STA/HLT mem[D]=%02h halted=%0b", dp_mem[13], halted);

        // LDI 7, SUB 0xC (mem[C]=7), JZ 9
        clear_img();
        img[0] = 8'h57; img[1] = 8'h3C; img[2] = 8'h89; img[9] = 8'hF0; img[12] = 8'h07;
        do_reset();
        tick(13 + SS_LAT);
        check("jz_pc_before_load", 128'(dp_pc), 128'(4'h3));
        tick(1);
        check("jz_pc_taken", 128'(dp_pc), 128'(4'h9));
        check("sub_a_zero", 128'(dp_a), 128'(8'h00));
        check("sub_zr", 128'(dp_zr), 128'(1));
        check("jz_back_t0", 128'(obs), 128'(OBS_T0));
        $display("txn LDI/SUB/JZ pc=%0h a=%02h zr=%0b", dp_pc, dp_a, dp_zr);

        // JC 4 with carry clear
        clear_img();
        img[0] = 8'h74;
        do_reset();
        base_pcdin = n_pcdin;
        tick(3 + SS_LAT);
        check("jc_nt_pc", 128'(dp_pc), 128'(4'h1));
        check("jc_nt_t0", 128'(obs), 128'(OBS_T0));
        check("jc_nt_no_pcdin", 128'(n_pcdin - base_pcdin), 128'(0));
        $display("txn JC not-taken pc=%0h", dp_pc);

        // Reserved opcode 0xB acts as NOP
        clear_img();
        img[0] = 8'hB5;
        do_reset();
        base_wr = n_wr;
        tick(3 + SS_LAT);
        check("op_b_pc", 128'(dp_pc), 128'(4'h1));
        check("op_b_t0", 128'(obs), 128'(OBS_T0));
        check("op_b_no_writes", 128'(n_wr - base_wr), 128'(0));
        $display("txn opcode 0xB as NOP pc=%0h", dp_pc);

`ifdef CPU_SINGLE_STEP_EN
        clear_img();
        step = 1'b0;
        do_reset();
        tick(5);
        check("ss_wait_pc", 128'(dp_pc), 128'(4'h0));
        step = 1'b1;
        tick(1);
        step = 1'b0;
        tick(12);
        check("ss_one_instr", 128'(dp_pc), 128'(4'h1));
        $display("txn single-step pulse pc=%0h", dp_pc);
        step = 1'b1;
`endif

        // Random programs checked against the instruction-level model
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
            k = int'($urandom_range(1, 10));
            model_init();
            model_run(k, cyc);
            do_reset();
            tick(cyc + SS_LAT);
            check("rnd_pc", 128'(dp_pc), 128'(m_pc));
            check("rnd_a", 128'(dp_a), 128'(m_a));
            check("rnd_mem", pack_dp_mem(), pack_m_mem());
            check("rnd_zr", 128'(dp_zr), 128'(m_zr));
            check("rnd_co", 128'(dp_co), 128'(m_co));
            check("rnd_halted", 128'(halted), 128'(m_halt));
            $display("txn rnd %0d: k=%0d cycles=%0d pc=%0h a=%02h halted=%0b",
                     t, k, cyc, dp_pc, dp_a, halted);
        end

        check("bus_contention", 128'(n_contend), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
